// File: rtl/fast_bram_ctrl_pkg.sv
// Shared defaults, operation encoding and helpers for the FAST_BRAM request/response controller.
// Statistics counters exist only when FAST_BRAM_CTRL_STATS_EN is defined.
package fast_bram_ctrl_pkg;

    localparam int DEFAULT_DATA_WIDTH = 36;
    localparam int DEFAULT_ADDR_WIDTH = 9;
    localparam int DEFAULT_RESP_DEPTH = 2;
    localparam int STAT_WIDTH         = 32;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } bram_op_e;

    // Classifies the request handshake of the current cycle.
    function automatic bram_op_e decode_op(
        input logic valid,
        input logic ready,
        input logic write
    );
        bram_op_e op;
        op = OP_NONE;
        if (valid && ready) begin
            op = write ? OP_WRITE : OP_READ;
        end
        return op;
    endfunction

endpackage

// File: rtl/fast_bram_resp_fifo.sv
// Small response FIFO with modulo-DEPTH pointers and an occupancy count
// that distinguishes full from empty. The head entry is presented combinationally.
module fast_bram_resp_fifo
    import fast_bram_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int DEPTH      = DEFAULT_RESP_DEPTH,
    localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_W-1:0]      count
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem[rd_ptr_q];

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: a cleared count makes any leftover entries unreachable.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/fast_bram_ctrl.sv
// Credit-based request/response front end for one FAST_BRAM port (read latency 2).
// Define FAST_BRAM_CTRL_STATS_EN to add accepted read/write counters.
module fast_bram_ctrl
    import fast_bram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int RESP_DEPTH = DEFAULT_RESP_DEPTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  bram_re,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_rd_addr,
    output logic [ADDR_WIDTH-1:0] bram_wr_addr,
    output logic [DATA_WIDTH-1:0] bram_di,
    input  logic [DATA_WIDTH-1:0] bram_do
`ifdef FAST_BRAM_CTRL_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_rd_count,
    output logic [STAT_WIDTH-1:0] stat_wr_count
`endif
);

    localparam int CRED_W = $clog2(RESP_DEPTH + 1);

    logic [CRED_W-1:0]     credit_q, credit_d;
    logic                  inflight_q, inflight_d;
    bram_op_e              op;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  pop;
    logic                  push;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CRED_W-1:0]     fifo_count;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  unused_fifo_count;

    // Gating with RST_N keeps the port closed while reset is held, even though credit sits at its full value.
    assign req_ready = RST_N && (credit_q != '0);

    always_comb begin
        op = decode_op(req_valid, req_ready, req_write);
    end

    assign rd_acc = (op == OP_READ);
    assign wr_acc = (op == OP_WRITE);

    assign bram_re      = rd_acc;
    assign bram_we      = wr_acc;
    assign bram_rd_addr = req_addr;
    assign bram_wr_addr = req_addr;
    assign bram_di      = req_data;

    assign resp_valid = !fifo_empty;
    assign resp_data  = fifo_head;
    assign pop        = resp_valid && resp_ready;

    // Credit already reserved the slot; the full term only matters if that invariant were broken.
    assign push = inflight_q && (!fifo_full || pop);

    assign unused_fifo_count = ^fifo_count;

    always_comb begin
        credit_d   = credit_q;
        inflight_d = rd_acc;
        if (rd_acc && !pop) begin
            credit_d = credit_q - CRED_W'(1);
        end else if (pop && !rd_acc) begin
            credit_d = credit_q + CRED_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            credit_q   <= CRED_W'(RESP_DEPTH);
            inflight_q <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            inflight_q <= inflight_d;
        end
    end

    fast_bram_resp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RESP_DEPTH)
    ) u_resp_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (push),
        .push_data (bram_do),
        .pop       (pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

`ifdef FAST_BRAM_CTRL_STATS_EN
    logic [STAT_WIDTH-1:0] rd_count_q, rd_count_d;
    logic [STAT_WIDTH-1:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (rd_acc) begin
            rd_count_d = rd_count_q + STAT_WIDTH'(1);
        end
        if (wr_acc) begin
            wr_count_d = wr_count_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign stat_rd_count = rd_count_q;
    assign stat_wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_fast_bram_ctrl.sv
// Directed bench: instance 0 uses the default response depth (2), instance 1 uses depth 3
// for the streaming and mid-operation reset cases. Each instance has its own BRAM model.
module tb_fast_bram_ctrl;
    import fast_bram_ctrl_pkg::*;

    localparam int DW = 36;
    localparam int AW = 9;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    logic          req_valid    [2];
    logic          req_write    [2];
    logic          resp_ready   [2];
    logic [AW-1:0] req_addr     [2];
    logic [DW-1:0] req_data     [2];
    logic          req_ready    [2];
    logic          resp_valid   [2];
    logic          bram_re      [2];
    logic          bram_we      [2];
    logic [DW-1:0] resp_data    [2];
    logic [DW-1:0] bram_di      [2];
    logic [AW-1:0] bram_rd_addr [2];
    logic [AW-1:0] bram_wr_addr [2];
`ifdef FAST_BRAM_CTRL_STATS_EN
    logic [STAT_WIDTH-1:0] stat_rd_count [2];
    logic [STAT_WIDTH-1:0] stat_wr_count [2];
`endif

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [DW-1:0] pat(input int a);
        return 36'hA_5000_0000 | DW'(a);
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [DW-1:0] mem [0:(1<<AW)-1];
        logic [DW-1:0] do_q;

        initial begin
            for (int a = 0; a < (1 << AW); a++) mem[a] = pat(a);
        end

        always @(posedge CLK) begin
            if (bram_we[gi]) mem[bram_wr_addr[gi]] <= bram_di[gi];
            if (bram_re[gi]) do_q <= mem[bram_rd_addr[gi]];
        end

        fast_bram_ctrl #(
            .DATA_WIDTH (DW),
            .ADDR_WIDTH (AW),
            .RESP_DEPTH (2 + gi)
        ) u_dut (
            .CLK          (CLK),
            .RST_N        (RST_N),
            .req_valid    (req_valid[gi]),
            .req_ready    (req_ready[gi]),
            .req_write    (req_write[gi]),
            .req_addr     (req_addr[gi]),
            .req_data     (req_data[gi]),
            .resp_valid   (resp_valid[gi]),
            .resp_ready   (resp_ready[gi]),
            .resp_data    (resp_data[gi]),
            .bram_re      (bram_re[gi]),
            .bram_we      (bram_we[gi]),
            .bram_rd_addr (bram_rd_addr[gi]),
            .bram_wr_addr (bram_wr_addr[gi]),
            .bram_di      (bram_di[gi]),
            .bram_do      (do_q)
`ifdef FAST_BRAM_CTRL_STATS_EN
            ,
            .stat_rd_count (stat_rd_count[gi]),
            .stat_wr_count (stat_wr_count[gi])
`endif
        );
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic w, input int a,
                         input logic [DW-1:0] dat, input logic rr);
        req_valid[d]  = v;
        req_write[d]  = w;
        req_addr[d]   = AW'(a);
        req_data[d]   = dat;
        resp_ready[d] = rr;
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b1;
        for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 0, '0, 1'b1);
        #2 RST_N = 1'b0;

        // Reset state: port closed even with a request offered
        drive(0, 1'b1, 1'b0, 5, '0, 1'b1);
        cyc(); cyc();
        check_eq("rst_req_ready0", req_ready[0], 1'b0);
        check_eq("rst_req_ready1", req_ready[1], 1'b0);
        check_eq("rst_resp_valid", resp_valid[0], 1'b0);
        check_eq("rst_bram_re", bram_re[0], 1'b0);
        drive(0, 1'b1, 1'b1, 5, 36'h123, 1'b1);
        #1;
        check_eq("rst_bram_we", bram_we[0], 1'b0);
        drive(0, 1'b0, 1'b0, 0, '0, 1'b1);
        RST_N = 1'b1;
        #1;
        check_eq("rel_req_ready0", req_ready[0], 1'b1);
        check_eq("rel_req_ready1", req_ready[1], 1'b1);
        cyc();

        // Write addr 5 then read it back
        drive(0, 1'b1, 1'b1, 5, 36'hABC, 1'b1);
        #1;
        check_eq("wr_we", bram_we[0], 1'b1);
        check_eq("wr_re", bram_re[0], 1'b0);
        check_eq("wr_addr", bram_wr_addr[0], 5);
        check_eq("wr_di", bram_di[0], 36'hABC);
        cyc();
        drive(0, 1'b1, 1'b0, 5, '0, 1'b1);
        #1;
        check_eq("rd_re", bram_re[0], 1'b1);
        check_eq("rd_we", bram_we[0], 1'b0);
        check_eq("rd_addr", bram_rd_addr[0], 5);
        check_eq("rd_T_valid", resp_valid[0], 1'b0);
        cyc();
        drive(0, 1'b0, 1'b0, 0, '0, 1'b1);
        #1;
        check_eq("rd_T1_valid", resp_valid[0], 1'b0);
        check_eq("rd_T1_re", bram_re[0], 1'b0);
        cyc();
        #1;
        check_eq("rd_T2_valid", resp_valid[0], 1'b1);
        check_eq("rd_T2_data", resp_data[0], 36'hABC);
        cyc();
        #1;
        check_eq("rd_T3_valid", resp_valid[0], 1'b0);
        cyc();

        // Credit exhaustion with consumer stalled, then simultaneous pop and accept
        drive(0, 1'b1, 1'b0, 1, '0, 1'b0);
        #1;
        check_eq("cr_acc0", req_ready[0], 1'b1);
        cyc();
        drive(0, 1'b1, 1'b0, 2, '0, 1'b0);
        #1;
        check_eq("cr_acc1", req_ready[0], 1'b1);
        cyc();
        drive(0, 1'b1, 1'b0, 3, '0, 1'b0);
        #1;
        check_eq("cr_block", req_ready[0], 1'b0);
        check_eq("cr_block_re", bram_re[0], 1'b0);
        cyc();
        #1;
        check_eq("cr_block2", req_ready[0], 1'b0);
        check_eq("cr_head_valid", resp_valid[0], 1'b1);
        check_eq("cr_head_data", resp_data[0], pat(1));
        cyc();
        drive(0, 1'b1, 1'b0, 3, '0, 1'b1);
        #1;
        check_eq("cr_hold_data", resp_data[0], pat(1));
        check_eq("cr_block3", req_ready[0], 1'b0);
        cyc();
        #1;
        check_eq("pa_ready", req_ready[0], 1'b1);
        check_eq("pa_re", bram_re[0], 1'b1);
        check_eq("pa_addr", bram_rd_addr[0], 3);
        check_eq("pa_data", resp_data[0], pat(2));
        cyc();
        drive(0, 1'b1, 1'b0, 4, '0, 1'b1);
        #1;
        check_eq("pa_ready_after", req_ready[0], 1'b1);
        check_eq("pa_gap_valid", resp_valid[0], 1'b0);
        cyc();
        drive(0, 1'b0, 1'b0, 0, '0, 1'b1);
        #1;
        check_eq("pa_credit_one", req_ready[0], 1'b0);
        check_eq("pa_resp3_valid", resp_valid[0], 1'b1);
        check_eq("pa_resp3_data", resp_data[0], pat(3));
        cyc();
        #1;
        check_eq("pa_resp4_data", resp_data[0], pat(4));
        check_eq("pa_ready_back", req_ready[0], 1'b1);
        cyc();
        #1;
        check_eq("pa_drained", resp_valid[0], 1'b0);
        cyc();

        // Streaming reads, one per cycle, on the depth-3 instance
        for (int k = 0; k < 12; k++) begin
            if (k < 8) drive(1, 1'b1, 1'b0, k, '0, 1'b1);
            else       drive(1, 1'b0, 1'b0, 0, '0, 1'b1);
            #1;
            if (k < 8) check_eq($sformatf("st_ready_%0d", k), req_ready[1], 1'b1);
            if (k >= 2 && k < 10) begin
                check_eq($sformatf("st_valid_%0d", k), resp_valid[1], 1'b1);
                check_eq($sformatf("st_data_%0d", k), resp_data[1], pat(k - 2));
            end else begin
                check_eq($sformatf("st_idle_%0d", k), resp_valid[1], 1'b0);
            end
            cyc();
        end

        // Reset with two responses buffered and one read in flight
        drive(1, 1'b1, 1'b0, 1, '0, 1'b0);
        cyc();
        drive(1, 1'b1, 1'b0, 2, '0, 1'b0);
        cyc();
        drive(1, 1'b1, 1'b0, 3, '0, 1'b0);
        #1;
        check_eq("mr_third_acc", req_ready[1], 1'b1);
        cyc();
        drive(1, 1'b0, 1'b0, 0, '0, 1'b0);
        #1;
        check_eq("mr_buffered", resp_valid[1], 1'b1);
        check_eq("mr_buffered_data", resp_data[1], pat(1));
        RST_N = 1'b0;
        #1;
        check_eq("mr_valid_drop", resp_valid[1], 1'b0);
        check_eq("mr_ready_drop", req_ready[1], 1'b0);
        cyc(); cyc();
        RST_N = 1'b1;
        #1;
        check_eq("mr_rel_ready", req_ready[1], 1'b1);
        check_eq("mr_rel_valid", resp_valid[1], 1'b0);
        cyc();
        #1;
        check_eq("mr_stale1", resp_valid[1], 1'b0);
        cyc();
        #1;
        check_eq("mr_stale2", resp_valid[1], 1'b0);
        cyc();
        drive(1, 1'b1, 1'b0, 6, '0, 1'b0);
        #1;
        check_eq("mr_cr0", req_ready[1], 1'b1);
        cyc();
        drive(1, 1'b1, 1'b0, 7, '0, 1'b0);
        #1;
        check_eq("mr_cr1", req_ready[1], 1'b1);
        cyc();
        drive(1, 1'b1, 1'b0, 0, '0, 1'b0);
        #1;
        check_eq("mr_cr2", req_ready[1], 1'b1);
        cyc();
        drive(1, 1'b1, 1'b0, 1, '0, 1'b0);
        #1;
        check_eq("mr_cr_full", req_ready[1], 1'b0);
        check_eq("mr_first_data", resp_data[1], pat(6));
        cyc();
        drive(1, 1'b0, 1'b0, 0, '0, 1'b1);
        #1;
        check_eq("mr_resp6", resp_data[1], pat(6));
        cyc();
        #1;
        check_eq("mr_resp7", resp_data[1], pat(7));
        cyc();
        #1;
        check_eq("mr_resp0", resp_data[1], pat(0));
        cyc();
        #1;
        check_eq("mr_empty", resp_valid[1], 1'b0);
        cyc();

`ifdef FAST_BRAM_CTRL_STATS_EN
        // Statistics: 4 writes and 3 reads since a fresh reset
        RST_N = 1'b0;
        #1;
        check_eq("stat_rst_rd", stat_rd_count[0], 0);
        check_eq("stat_rst_wr", stat_wr_count[0], 0);
        cyc();
        RST_N = 1'b1;
        cyc();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b1, 1'b1, 10 + k, DW'(k), 1'b1);
            cyc();
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, 1'b0, 10 + k, '0, 1'b1);
            cyc();
            drive(0, 1'b0, 1'b0, 0, '0, 1'b1);
            cyc(); cyc();
        end
        #1;
        check_eq("stat_wr", stat_wr_count[0], 4);
        check_eq("stat_rd", stat_rd_count[0], 3);
        RST_N = 1'b0;
        #1;
        check_eq("stat_clr_wr", stat_wr_count[0], 0);
        check_eq("stat_clr_rd", stat_rd_count[0], 0);
        cyc();
        RST_N = 1'b1;
        cyc();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
